// File: rtl/counter_pkg.sv
// Shared constants for mod_counter: run-mode encodings and direction values.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE. tick is high on the enabled cycle in which
// the phase counter sits at PRESCALE-1; clear restarts the phase at 0.
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = enable && (cnt_q == LAST);

    // Next phase: clear wins, enable advances, otherwise frozen.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down counter with load and wrap/saturate/one-shot modes.
// Optional build macro: COUNTER_PRESCALE_EN (steps only every PRESCALE enabled cycles).
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             at_limit,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2) begin : g_bad_width
        $error("mod_counter: WIDTH must be >= 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
        $error("mod_counter: MAX_VAL out of range");
    end
    if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("mod_counter: RESET_VAL out of range");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             lim_q, lim_d;
    logic             done_q, done_d;

    logic             pre_tick;
    logic             step;
    logic [WIDTH-1:0] bnd;
    logic [WIDTH-1:0] load_clamped;
    mode_e            mode_sel;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (load),
        .enable (enable),
        .tick   (pre_tick)
    );
`else
    assign pre_tick = 1'b1;
`endif

    assign mode_sel     = mode_e'(mode);
    assign bnd          = (up_down == DIR_UP) ? MAX_V : '0;
    assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
    // A set done flag blocks every step, whatever the current mode.
    assign step         = enable && !load && pre_tick && !done_q;

    // Next-state: load > step > hold; at_limit compares the next value.
    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (load) begin
            cnt_d  = load_clamped;
            done_d = 1'b0;
        end else if (step) begin
            case (mode_sel)
                MODE_SAT, MODE_ONESHOT: begin
                    if (cnt_q != bnd) begin
                        cnt_d = (up_down == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
                        if (cnt_d == bnd) begin
                            tc_d = 1'b1;
                            if (mode_sel == MODE_ONESHOT) begin
                                done_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (up_down == DIR_UP) begin
                        if (cnt_q == MAX_V) begin
                            cnt_d = '0;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            cnt_d = MAX_V;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
            endcase
        end
        lim_d = (cnt_d == bnd);
    end

    // Output registers with synchronous reset; at_limit resets assuming up direction.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= RESET_V;
            tc_q   <= 1'b0;
            lim_q  <= (RESET_V == MAX_V);
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            lim_q  <= lim_d;
            done_q <= done_d;
        end
    end

    assign counter_out = cnt_q;
    assign tc          = tc_q;
    assign at_limit    = lim_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=4, MAX_VAL=9, RESET_VAL=0).
module tb_mod_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic [1:0] mode;
    logic [3:0] counter_out;
    logic       tc;
    logic       at_limit;
    logic       done;

    int checks = 0;
    int errors = 0;

    mod_counter #(
        .WIDTH     (4),
        .MAX_VAL   (9),
        .RESET_VAL (0),
        .PRESCALE  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .up_down     (up_down),
        .load        (load),
        .load_value  (load_value),
        .mode        (mode),
        .counter_out (counter_out),
        .tc          (tc),
        .at_limit    (at_limit),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int t, input int l, input int d);
        chk({tag, ".cnt"},  32'(counter_out), 32'(c));
        chk({tag, ".tc"},   32'(tc),          32'(t));
        chk({tag, ".lim"},  32'(at_limit),    32'(l));
        chk({tag, ".done"}, 32'(done),        32'(d));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        load_value = '0; mode = 2'b00;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

`ifndef COUNTER_PRESCALE_EN
        // Wrap up: 1..9,0,1,2 with tc when 0 first appears.
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk_all("wrap_up", i % 10, (i == 10) ? 1 : 0, ((i % 10) == 9) ? 1 : 0, 0);
        end
        enable = 1'b0;

        // Wrap down: load 2 then 1,0,9,8.
        load = 1'b1; load_value = 4'd2;
        tick();
        chk_all("wrap_dn_load", 2, 0, 0, 0);
        load = 1'b0; up_down = 1'b0; enable = 1'b1;
        tick(); chk_all("wrap_dn1", 1, 0, 0, 0);
        tick(); chk_all("wrap_dn2", 0, 0, 1, 0);
        tick(); chk_all("wrap_dn3", 9, 1, 0, 0);
        tick(); chk_all("wrap_dn4", 8, 0, 0, 0);
        enable = 1'b0;
        tick(); chk_all("hold", 8, 0, 0, 0);

        // Saturate up from 7.
        mode = 2'b01; up_down = 1'b1; load = 1'b1; load_value = 4'd7;
        tick(); chk_all("sat_load", 7, 0, 0, 0);
        load = 1'b0; enable = 1'b1;
        tick(); chk_all("sat1", 8, 0, 0, 0);
        tick(); chk_all("sat2", 9, 1, 1, 0);
        tick(); chk_all("sat3", 9, 0, 1, 0);
        tick(); chk_all("sat4", 9, 0, 1, 0);
        tick(); chk_all("sat5", 9, 0, 1, 0);
        up_down = 1'b0;
        tick(); chk_all("sat_away", 8, 0, 0, 0);
        enable = 1'b0;

        // Saturate down onto 0 then hold there.
        load = 1'b1; load_value = 4'd1;
        tick(); chk_all("satdn_load", 1, 0, 0, 0);
        load = 1'b0; enable = 1'b1;
        tick(); chk_all("satdn1", 0, 1, 1, 0);
        tick(); chk_all("satdn2", 0, 0, 1, 0);
        enable = 1'b0;

        // One-shot from 8, done sticks and blocks even after mode change.
        mode = 2'b10; up_down = 1'b1; load = 1'b1; load_value = 4'd8;
        tick(); chk_all("os_load", 8, 0, 0, 0);
        load = 1'b0; enable = 1'b1;
        tick(); chk_all("os1", 9, 1, 1, 1);
        tick(); chk_all("os2", 9, 0, 1, 1);
        mode = 2'b00;
        tick(); chk_all("os_wrapblk", 9, 0, 1, 1);
        mode = 2'b10; up_down = 1'b0;
        tick(); chk_all("os_dnblk", 9, 0, 0, 1);
        up_down = 1'b1; load = 1'b1; load_value = 4'd3;
        tick(); chk_all("os_rearm", 3, 0, 0, 0);
        load = 1'b0;
        tick(); chk_all("os_run1", 4, 0, 0, 0);
        tick(); chk_all("os_run2", 5, 0, 0, 0);
        enable = 1'b0;

        // Priority and clamp.
        mode = 2'b00; load = 1'b1; load_value = 4'd15; enable = 1'b1;
        tick(); chk_all("clamp", 9, 0, 1, 0);
        load = 1'b0; enable = 1'b0; mode = 2'b11;
        enable = 1'b1;
        tick(); chk_all("rsvd_wrap", 0, 1, 0, 0);
        enable = 1'b0;
        reset = 1'b1; load = 1'b1; load_value = 4'd5;
        tick(); chk_all("rst_over_load", 0, 0, 0, 0);
        reset = 1'b0; load = 1'b0;
`else
        // Prescale by 4: steps on enabled cycles 4, 8, 12.
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk_all("pre", i / 4, 0, 0, 0);
        end
        enable = 1'b0;
        tick(); chk_all("pre_freeze", 3, 0, 0, 0);
        load = 1'b1; load_value = 4'd0;
        tick(); chk_all("pre_load0", 0, 0, 0, 0);
        load = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("pre_a", i / 4, 0, 0, 0);
        end
        // Load at cycle 6 restarts the phase.
        load = 1'b1; load_value = 4'd0;
        tick(); chk_all("pre_load6", 0, 0, 0, 0);
        load = 1'b0;
        for (int i = 7; i <= 10; i++) begin
            tick();
            chk_all("pre_b", (i == 10) ? 1 : 0, 0, 0, 0);
        end
        enable = 1'b0;
        reset = 1'b1;
        tick(); chk_all("pre_reset", 0, 0, 0, 0);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
